// File: rtl/packet_generator.sv
`default_nettype none
// ============================================================================
//  Module      : packet_generator
//  Description : Framed traffic source for the simulated-ethernet fabric.
//                Emits packets of a programmable length and count, with a
//                programmable inter-packet gap and data pattern, to a single
//                destination. It provides run/stop control, busy/done status
//                and a count of packets sent.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, resetn          clock; synchronous active-low reset
//    start, stop          run control pulses
//    cfg_dest/len/count/gap/mode/seed
//                         run configuration, captured when a start is accepted
//    tx_data/addr/valid/sop/eop, tx_ready
//                         beat stream to the sink (valid/ready handshake)
//    busy, done           status: busy in SEND/GAP, done pulses at end of run
//    pkts_sent            packets completed since last accepted start
// ============================================================================
module packet_generator #(
    parameter int DW    = 64,
    parameter int AW    = 4,
    parameter int LEN_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic [AW-1:0]    cfg_dest,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [LEN_W-1:0] cfg_gap,
    input  logic [1:0]       cfg_mode,
    input  logic [DW-1:0]    cfg_seed,
    output logic [DW-1:0]    tx_data,
    output logic [AW-1:0]    tx_addr,
    output logic             tx_valid,
    output logic             tx_sop,
    output logic             tx_eop,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkts_sent
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] MODE_TAGGED = 2'd1;
    localparam logic [1:0] MODE_CONST  = 2'd2;

    localparam int HW = DW / 2;

    logic [1:0]       state_q,     state_d;
    logic [LEN_W-1:0] beat_q,      beat_d;
    logic [LEN_W-1:0] gap_cnt_q,   gap_cnt_d;
    logic [CNT_W-1:0] pkts_q,      pkts_d;
    logic             stop_pend_q, stop_pend_d;
    logic [DW-1:0]    incr_q,      incr_d;
    logic [LEN_W-1:0] len_q,       len_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [LEN_W-1:0] gap_q,       gap_d;
    logic [1:0]       mode_q,      mode_d;
    logic [DW-1:0]    seed_q,      seed_d;
    logic [AW-1:0]    dest_q,      dest_d;

    logic             w_last;
    logic             w_sending;
    logic [HW-1:0]    w_pkt_tag;
    logic [HW-1:0]    w_beat_tag;
    logic [DW-1:0]    w_pattern;

    assign w_sending = (state_q == ST_SEND);
    // len_q is never 0 (0 is promoted to 1 at capture), so len_q-1 is safe.
    assign w_last    = (beat_q == len_q - LEN_W'(1));

    // Fit packet index and beat index into half a data word each,
    // truncating or zero-extending depending on the parameter set.
    if (CNT_W >= HW) begin : g_pkt_trunc
        assign w_pkt_tag = pkts_q[HW-1:0];
    end else begin : g_pkt_ext
        assign w_pkt_tag = {{(HW-CNT_W){1'b0}}, pkts_q};
    end

    if (LEN_W >= HW) begin : g_beat_trunc
        assign w_beat_tag = beat_q[HW-1:0];
    end else begin : g_beat_ext
        assign w_beat_tag = {{(HW-LEN_W){1'b0}}, beat_q};
    end

    always_comb begin
        case (mode_q)
            MODE_TAGGED: w_pattern = {w_pkt_tag, w_beat_tag};
            MODE_CONST:  w_pattern = seed_q;
            default:     w_pattern = incr_q;   // INCR and reserved mode
        endcase
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        gap_cnt_d   = gap_cnt_q;
        pkts_d      = pkts_q;
        stop_pend_d = stop_pend_q;
        incr_d      = incr_q;
        len_d       = len_q;
        count_d     = count_q;
        gap_d       = gap_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        dest_d      = dest_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    len_d       = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                    count_d     = cfg_count;
                    gap_d       = cfg_gap;
                    mode_d      = cfg_mode;
                    seed_d      = cfg_seed;
                    dest_d      = cfg_dest;
                    beat_d      = '0;
                    pkts_d      = '0;
                    stop_pend_d = 1'b0;
                    incr_d      = cfg_seed;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                // tx_valid is always high in SEND, so tx_ready alone
                // marks an accepted beat.
                if (tx_ready) begin
                    incr_d = incr_q + DW'(1);
                    if (w_last) begin
                        beat_d = '0;
                        pkts_d = pkts_q + CNT_W'(1);
                        // A stop arriving on the eop beat itself also ends
                        // the run after this packet.
                        if (((count_q != '0) && (pkts_q + CNT_W'(1) == count_q))
                            || stop_pend_q || stop) begin
                            state_d = ST_DONE;
                        end else if (gap_q != '0) begin
                            gap_cnt_d = gap_q;
                            state_d   = ST_GAP;
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (gap_cnt_q == LEN_W'(1)) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - LEN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            gap_cnt_q   <= '0;
            pkts_q      <= '0;
            stop_pend_q <= 1'b0;
            incr_q      <= '0;
            len_q       <= LEN_W'(1);
            count_q     <= '0;
            gap_q       <= '0;
            mode_q      <= '0;
            seed_q      <= '0;
            dest_q      <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            gap_cnt_q   <= gap_cnt_d;
            pkts_q      <= pkts_d;
            stop_pend_q <= stop_pend_d;
            incr_q      <= incr_d;
            len_q       <= len_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            dest_q      <= dest_d;
        end
    end

    // All outputs decode registered state, so they are stable while stalled.
    assign tx_valid  = w_sending;
    assign tx_sop    = w_sending && (beat_q == '0);
    assign tx_eop    = w_sending && w_last;
    assign tx_data   = w_sending ? w_pattern : '0;
    assign tx_addr   = dest_q;
    assign busy      = w_sending || (state_q == ST_GAP);
    assign done      = (state_q == ST_DONE);
    assign pkts_sent = pkts_q;

endmodule
`default_nettype wire

// File: tb/tb_packet_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_generator
//  Description : Scoreboard bench for packet_generator. Expected beats are
//                queued when a run is started and compared as the DUT
//                transfers them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_generator;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int LW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start, stop;
    logic [AW-1:0] cfg_dest;
    logic [LW-1:0] cfg_len, cfg_gap;
    logic [CW-1:0] cfg_count;
    logic [1:0]    cfg_mode;
    logic [DW-1:0] cfg_seed;
    logic [DW-1:0] tx_data;
    logic [AW-1:0] tx_addr;
    logic          tx_valid, tx_sop, tx_eop, tx_ready;
    logic          busy, done;
    logic [CW-1:0] pkts_sent;

    packet_generator #(.DW(DW), .AW(AW), .LEN_W(LW), .CNT_W(CW)) u_dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .stop     (stop),
        .cfg_dest (cfg_dest),
        .cfg_len  (cfg_len),
        .cfg_count(cfg_count),
        .cfg_gap  (cfg_gap),
        .cfg_mode (cfg_mode),
        .cfg_seed (cfg_seed),
        .tx_data  (tx_data),
        .tx_addr  (tx_addr),
        .tx_valid (tx_valid),
        .tx_sop   (tx_sop),
        .tx_eop   (tx_eop),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .pkts_sent(pkts_sent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [AW-1:0] addr;
    } beat_t;

    beat_t exp_q[$];
    int    beat_cyc[$];
    int    cyc      = 0;
    int    n_beats  = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    checks   = 0;
    int    errors   = 0;

    logic          stall_v = 1'b0;
    logic [DW-1:0] h_data;
    logic          h_sop, h_eop;
    logic [AW-1:0] h_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!resetn) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, h_data);
                check("stall_ctl", {tx_sop, tx_eop, tx_addr}, {h_sop, h_eop, h_addr});
            end
            stall_v = tx_valid && !tx_ready;
            h_data  = tx_data;
            h_sop   = tx_sop;
            h_eop   = tx_eop;
            h_addr  = tx_addr;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 64'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", tx_data, e.data);
                    check("beat_sop_eop", {tx_sop, tx_eop}, {e.sop, e.eop});
                    check("beat_addr", tx_addr, e.addr);
                end
                beat_cyc.push_back(cyc);
                n_beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected beats of npk packets.
    task automatic push_pkts(input int len, input int npk, input int mode,
                             input logic [DW-1:0] seed, input logic [AW-1:0] dest);
        int            l;
        logic [DW-1:0] acc;
        beat_t         e;
        l   = (len == 0) ? 1 : len;
        acc = seed;
        for (int p = 0; p < npk; p++) begin
            for (int b = 0; b < l; b++) begin
                case (mode)
                    1:       e.data = {32'(p), 32'(b)};
                    2:       e.data = seed;
                    default: e.data = acc;
                endcase
                e.sop  = (b == 0);
                e.eop  = (b == l - 1);
                e.addr = dest;
                exp_q.push_back(e);
                acc = acc + 64'd1;
            end
        end
    endtask

    task automatic start_run(input int len, input int count, input int gap, input int mode,
                             input logic [DW-1:0] seed, input logic [AW-1:0] dest);
        cfg_len   = LW'(len);
        cfg_count = CW'(count);
        cfg_gap   = LW'(gap);
        cfg_mode  = 2'(mode);
        cfg_seed  = seed;
        cfg_dest  = dest;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(done_cnt - d0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nb0;
        int k;
        resetn    = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        tx_ready  = 1'b1;
        cfg_dest  = '0;
        cfg_len   = '0;
        cfg_count = '0;
        cfg_gap   = '0;
        cfg_mode  = '0;
        cfg_seed  = '0;
        repeat (3) tick();
        check("rst_valid", tx_valid, 0);
        check("rst_sop_eop", {tx_sop, tx_eop}, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_data", tx_data, 0);
        check("rst_addr", tx_addr, 0);
        check("rst_pkts", pkts_sent, 0);
        resetn = 1'b1;
        tick();

        // 1: two back-to-back INCR packets of 4 beats
        beat_cyc.delete();
        push_pkts(4, 2, 0, 64'd0, 4'd2);
        start_run(4, 2, 0, 0, 64'd0, 4'd2);
        check("t1_first_beat", {tx_valid, tx_sop}, 2'b11);
        wait_done("t1_done", 60);
        check("t1_sb_empty", 64'(exp_q.size()), 0);
        check("t1_nbeats", 64'(beat_cyc.size()), 8);
        if (beat_cyc.size() >= 8) begin
            check("t1_continuous", 64'(beat_cyc[7] - beat_cyc[0]), 7);
            check("t1_done_lat", 64'(done_cyc - beat_cyc[7]), 1);
        end
        check("t1_pkts", pkts_sent, 2);
        check("t1_idle_busy", busy, 0);

        // 2: single-beat CONST packets with a 2-cycle gap
        beat_cyc.delete();
        push_pkts(1, 3, 2, 64'hA5, 4'd1);
        start_run(1, 3, 2, 2, 64'hA5, 4'd1);
        wait_done("t2_done", 60);
        check("t2_sb_empty", 64'(exp_q.size()), 0);
        check("t2_nbeats", 64'(beat_cyc.size()), 3);
        if (beat_cyc.size() >= 3) begin
            check("t2_gap0", 64'(beat_cyc[1] - beat_cyc[0]), 3);
            check("t2_gap1", 64'(beat_cyc[2] - beat_cyc[1]), 3);
            check("t2_done_lat", 64'(done_cyc - beat_cyc[2]), 1);
        end
        check("t2_pkts", pkts_sent, 3);

        // 3: TAGGED with ready toggling
        beat_cyc.delete();
        push_pkts(3, 1, 1, 64'd0, 4'd7);
        tx_ready = 1'b0;
        start_run(3, 1, 0, 1, 64'd0, 4'd7);
        nb0 = done_cnt;
        for (int i = 0; i < 40 && done_cnt == nb0; i++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        tx_ready = 1'b1;
        check("t3_done", 64'(done_cnt - nb0), 1);
        check("t3_sb_empty", 64'(exp_q.size()), 0);
        check("t3_nbeats", 64'(beat_cyc.size()), 3);

        // 4: endless run stopped mid-packet 5; packet completes
        beat_cyc.delete();
        push_pkts(8, 6, 0, 64'h1000, 4'd4);
        start_run(8, 0, 0, 0, 64'h1000, 4'd4);
        nb0 = n_beats;
        k   = 0;
        while (n_beats - nb0 < 42 && k < 200) begin
            tick();
            k++;
        end
        check("t4_reach_stop_point", 64'(n_beats - nb0), 42);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t4_done", 60);
        check("t4_sb_empty", 64'(exp_q.size()), 0);
        check("t4_nbeats", 64'(beat_cyc.size()), 48);
        check("t4_pkts", pkts_sent, 6);

        // 5: start while busy ignored; stop+start together in IDLE ignored
        push_pkts(2, 3, 0, 64'h100, 4'd3);
        start_run(2, 3, 1, 0, 64'h100, 4'd3);
        tick();
        cfg_len  = 16'd7;
        cfg_seed = 64'hFFFF;
        cfg_dest = 4'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done("t5_done", 60);
        check("t5_sb_empty", 64'(exp_q.size()), 0);
        check("t5_pkts", pkts_sent, 3);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t5_idle_valid", tx_valid, 0);
        check("t5_idle_busy", busy, 0);
        repeat (3) tick();
        check("t5_still_idle", {tx_valid, busy, done}, 0);
        check("t5_pkts_kept", pkts_sent, 3);

        // 6: reset mid-packet, then a fresh run
        push_pkts(8, 1, 0, 64'd0, 4'd6);
        start_run(8, 0, 0, 0, 64'd0, 4'd6);
        repeat (3) tick();
        resetn = 1'b0;
        exp_q.delete();
        tick();
        check("t6_rst_valid", tx_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_pkts", pkts_sent, 0);
        check("t6_rst_eop", tx_eop, 0);
        resetn = 1'b1;
        tick();
        push_pkts(2, 1, 2, 64'h5A, 4'd6);
        start_run(2, 1, 0, 2, 64'h5A, 4'd6);
        check("t6_fresh_sop", {tx_valid, tx_sop}, 2'b11);
        wait_done("t6_done", 30);
        check("t6_sb_empty", 64'(exp_q.size()), 0);
        check("t6_pkts", pkts_sent, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
